// File: rtl/data_gate_ctrl.sv
// Upstream qualifier: synchronises and debounces a raw data level, gates it through
// an OFF/ARM/ON enable FSM, and counts gated rising edges with saturation.
module data_gate_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data,
  input  logic             enable,
  input  logic             clr,
  output logic             gate,
  output logic             data_q,
  output logic             rise,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned     DC_W   = $clog2(DEBOUNCE) + 1;
  localparam logic [DC_W-1:0] DC_MAX = DC_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_ARM,
    ST_ON
  } state_e;

  state_e                 state_q;
  logic                   gate_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s;
  logic [DC_W-1:0]        dc_q;
  logic [DC_W-1:0]        dc_d;
  logic                   dq_q;
  logic                   dq_d;
  logic                   rise_q;
  logic                   rise_d;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], data};
  assign s      = sync_q[SYNC_STAGES-1];

  // Debounce: data_q follows s only after DEBOUNCE consecutive disagreeing edges.
  always_comb begin
    dc_d    = dc_q;
    dq_d    = dq_q;
    rise_d  = 1'b0;
    count_d = count_q;
    if (s == dq_q) begin
      dc_d = '0;
    end else if (dc_q != DC_MAX) begin
      dc_d = dc_q + DC_W'(1);
    end else begin
      dc_d   = '0;
      dq_d   = s;
      rise_d = s;
    end
    if (clr) begin
      count_d = '0;
    end else if (rise_q && gate_q && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      dc_q    <= '0;
      dq_q    <= 1'b0;
      rise_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync_q  <= sync_d;
      dc_q    <= dc_d;
      dq_q    <= dq_d;
      rise_q  <= rise_d;
      count_q <= count_d;
    end
  end

  // ARM waits for a known-low data_q baseline before opening the gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      gate_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (enable) state_q <= ST_ARM;
        end
        ST_ARM: begin
          if (!enable) begin
            state_q <= ST_OFF;
          end else if (!dq_q) begin
            state_q <= ST_ON;
            gate_q  <= 1'b1;
          end
        end
        ST_ON: begin
          if (!enable) begin
            state_q <= ST_OFF;
            gate_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_OFF;
          gate_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gate   = gate_q;
  assign data_q = dq_q;
  assign rise   = rise_q;
  assign count  = count_q;

endmodule

// File: tb/tb_data_gate_ctrl.sv
// Bench for data_gate_ctrl: directed scenarios plus random stimulus, all checked
// against an edge-history reference model (8-bit and 3-bit count instances).
module tb_data_gate_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data = 1'b0;
  logic       enable = 1'b0;
  logic       clr = 1'b0;
  logic       gate, data_q, rise;
  logic [7:0] count;
  logic       gate3, data_q3, rise3;
  logic [2:0] count3;

  int errors = 0;
  int checks = 0;

  data_gate_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .enable(enable), .clr(clr),
    .gate(gate), .data_q(data_q), .rise(rise), .count(count)
  );

  data_gate_ctrl #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .CNT_W(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .data(data), .enable(enable), .clr(clr),
    .gate(gate3), .data_q(data_q3), .rise(rise3), .count(count3)
  );

  always #5 clk = ~clk;

  // Reference model: keeps every sampled data bit since reset and decides each edge
  // from the window of synchronised values since the last data_q change.
  bit         dh[$];
  int         e_n = 0;
  int         last_chg = 0;
  bit         m_dq = 1'b0;
  bit         m_rise = 1'b0;
  bit         m_gate = 1'b0;
  int         m_st = 0;   // 0 OFF, 1 ARM, 2 ON
  logic [7:0] m_c8 = '0;
  logic [2:0] m_c3 = '0;

  function automatic bit s_at(int j);
    int k;
    k = j - int'(SYNC);
    if (k >= 1) return dh[k-1];
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dh.delete();
      e_n = 0; last_chg = 0;
      m_dq = 1'b0; m_rise = 1'b0; m_gate = 1'b0; m_st = 0;
      m_c8 = '0; m_c3 = '0;
    end else begin
      bit chg;
      int ns;
      e_n++;
      dh.push_back(data);
      chg = 1'b1;
      for (int j = e_n - int'(DEB) + 1; j <= e_n; j++)
        if (j <= last_chg || s_at(j) == m_dq) chg = 1'b0;
      ns = m_st;
      case (m_st)
        0: if (enable) ns = 1;
        1: if (!enable) ns = 0; else if (!m_dq) ns = 2;
        default: if (!enable) ns = 0;
      endcase
      if (clr) begin
        m_c8 = '0; m_c3 = '0;
      end else if (m_rise && m_gate) begin
        if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
        if (m_c3 != 3'h7) m_c3 = m_c3 + 3'd1;
      end
      m_rise = chg && !m_dq;
      if (chg) begin
        m_dq = !m_dq;
        last_chg = e_n;
      end
      m_st = ns;
      m_gate = (ns == 2);
    end
  end

  logic [16:0] act_v, exp_v;
  assign act_v = {gate, data_q, rise, count, gate3, data_q3, rise3, count3};
  assign exp_v = {m_gate, m_dq, m_rise, m_c8, m_gate, m_dq, m_rise, m_c3};

  task automatic test_reset;
    data = 1'b1; enable = 1'b0; clr = 1'b0; rst_n = 1'b0;
    #2;
    checks++;
    if (act_v !== 17'd0) begin
      errors++; $display("FAIL reset_noclk t=%0t got=%h want=0", $time, act_v);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (act_v !== 17'd0) begin
      errors++; $display("FAIL reset_held t=%0t got=%h want=0", $time, act_v);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checks++;
      if (data_q !== (k >= 6) || rise !== (k == 6) || gate !== 1'b0 || count !== 8'd0) begin
        errors++;
        $display("FAIL reset_relearn edge=%0d got dq=%b rise=%b gate=%b cnt=%0d", k, data_q, rise, gate, count);
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL reset_model edge=%0d got=%h want=%h", k, act_v, exp_v);
      end
    end
    data = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (data_q !== 1'b0) begin
      errors++; $display("FAIL reset_fall got dq=%b want 0", data_q);
    end
  endtask

  task automatic test_glitch;
    bit saw;
    for (int g = 0; g < 6; g++) begin
      int len;
      len = $urandom_range(1, DEB - 1);
      for (int c = 0; c < len + 10; c++) begin
        @(negedge clk);
        checks++;
        if (data_q !== 1'b0 || rise !== 1'b0 || count !== 8'd0) begin
          errors++;
          $display("FAIL glitch len=%0d got dq=%b rise=%b cnt=%0d want 0", len, data_q, rise, count);
        end
        checks++;
        if (act_v !== exp_v) begin
          errors++; $display("FAIL glitch_model got=%h want=%h", act_v, exp_v);
        end
        data = (c < len);
      end
    end
    // A pulse exactly DEBOUNCE samples long is the shortest one that gets through.
    saw = 1'b0;
    for (int c = 0; c < int'(DEB) + 12; c++) begin
      @(negedge clk);
      if (data_q === 1'b1) saw = 1'b1;
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL glitch_edge_model got=%h want=%h", act_v, exp_v);
      end
      data = (c < int'(DEB));
    end
    checks++;
    if (saw !== 1'b1) begin
      errors++; $display("FAIL glitch_min_pass got seen=%b want 1", saw);
    end
  endtask

  task automatic test_gate_fsm;
    int n;
    @(negedge clk); enable = 1'b1;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0) begin errors++; $display("FAIL gate_edge1 got=%b want 0", gate); end
    @(negedge clk);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL gate_edge2 got=%b want 1", gate); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0) begin errors++; $display("FAIL gate_close got=%b want 0", gate); end
    data = 1'b1;
    n = 0;
    while (data_q !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL gate_dq_rise_timeout got dq=%b want 1", data_q); end
    enable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (gate !== 1'b0 || act_v !== exp_v) begin
        errors++; $display("FAIL gate_arm_hold got gate=%b vec=%h want gate=0 vec=%h", gate, act_v, exp_v);
      end
    end
    data = 1'b0;
    n = 0;
    while (data_q !== 1'b0 && n < 20) begin
      @(negedge clk); n++;
      checks++;
      if (gate !== 1'b0) begin errors++; $display("FAIL gate_arm_wait got=%b want 0", gate); end
    end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL gate_dq_fall_timeout got dq=%b want 0", data_q); end
    @(negedge clk);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL gate_after_low got=%b want 1", gate); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0) begin errors++; $display("FAIL gate_close2 got=%b want 0", gate); end
  endtask

  task automatic test_counting;
    int  rises;
    int  n;
    bit  prev;
    @(negedge clk); enable = 1'b1; clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL count_gate_open got=%b want 1", gate); end
    rises = 0; prev = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++;
        if (act_v !== exp_v) begin
          errors++; $display("FAIL count_model got=%h want=%h", act_v, exp_v);
        end
        if (rise === 1'b1) rises++;
        checks++;
        if (rise === 1'b1 && prev) begin errors++; $display("FAIL rise_double got=11 want 10"); end
        prev = rise;
        data = (c < 8);
      end
    end
    checks++;
    if (rises != 5 || count !== 8'd5 || count3 !== 3'd5) begin
      errors++; $display("FAIL count_five got rises=%0d cnt=%0d cnt3=%0d want 5", rises, count, count3);
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++;
    if (count !== 8'd0 || count3 !== 3'd0) begin
      errors++; $display("FAIL count_clr got cnt=%0d cnt3=%0d want 0", count, count3);
    end
    // A rise in the cycle enable drops is still counted.
    data = 1'b1; n = 0;
    while (rise !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL count_rise_timeout got rise=%b want 1", rise); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (gate !== 1'b0 || count !== 8'd1) begin
      errors++; $display("FAIL count_on_disable got gate=%b cnt=%0d want gate=0 cnt=1", gate, count);
    end
    data = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_saturation;
    int         n;
    logic [2:0] prev3;
    @(negedge clk); enable = 1'b1; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    prev3 = count3;
    for (int p = 0; p < 10; p++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++;
        if (act_v !== exp_v || (prev3 != 3'd0 && count3 === 3'd0)) begin
          errors++; $display("FAIL sat_model got=%h want=%h prev3=%0d", act_v, exp_v, prev3);
        end
        prev3 = count3;
        data = (c < 8);
      end
    end
    checks++;
    if (count !== 8'd10 || count3 !== 3'd7) begin
      errors++; $display("FAIL sat_final got cnt=%0d cnt3=%0d want 10 and 7", count, count3);
    end
    data = 1'b1; n = 0;
    while (rise !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL sat_rise_timeout got rise=%b want 1", rise); end
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    checks++;
    if (count !== 8'd0 || count3 !== 3'd0) begin
      errors++; $display("FAIL clr_beats_rise got cnt=%0d cnt3=%0d want 0", count, count3);
    end
    data = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_async_reset;
    @(negedge clk); enable = 1'b1; clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        checks++;
        if (act_v !== exp_v) begin
          errors++; $display("FAIL arst_model got=%h want=%h", act_v, exp_v);
        end
        data = (c < 8);
      end
    end
    checks++;
    if (gate !== 1'b1 || count !== 8'd3) begin
      errors++; $display("FAIL arst_pre got gate=%b cnt=%0d want 1 and 3", gate, count);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (act_v !== 17'd0) begin
      errors++; $display("FAIL arst_immediate got=%h want=0", act_v);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (gate !== 1'b0 || act_v !== exp_v) begin
        errors++; $display("FAIL arst_off got gate=%b vec=%h want gate=0 vec=%h", gate, act_v, exp_v);
      end
    end
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (gate !== 1'b1) begin errors++; $display("FAIL arst_reopen got=%b want 1", gate); end
  endtask

  task automatic test_random;
    int hold;
    hold = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random cyc=%0d got=%h want=%h", c, act_v, exp_v);
      end
      if (hold == 0) begin
        data = ~data;
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      clr = ($urandom_range(0, 39) == 0);
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_gate_fsm();
    test_counting();
    test_saturation();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
